// File: rtl/myfilter_pkg.sv
// Shared filter types: dmem command encoding, delay-line sequencer states and
// the modulo-DMEMSIZE pointer step used by the delay-line pointers.
package myfilter_pkg;
  localparam int DMEMSIZE  = 16;
  localparam int DATABITS  = 16;
  localparam int DMEM_AW   = (DMEMSIZE > 1) ? $clog2(DMEMSIZE) : 1;
  localparam int DMEM_TAPS = 8;

  typedef enum logic [1:0] {
    DMEM_NOP   = 2'd0,
    DMEM_WRITE = 2'd1,
    DMEM_READ  = 2'd2
  } dmem_cmd_t;

  typedef enum logic [2:0] {
    ST_INIT, ST_IDLE, ST_WRITE, ST_READ, ST_DRAIN
  } dmem_ctrl_state_t;

  typedef struct packed {
    dmem_cmd_t               cmd;
    logic [DMEM_AW-1:0]      addr;
    logic [DATABITS-1:0]     ext;
  } dmem_req_t;

  // DMEMSIZE need not be a power of two, so wrap on explicit compares.
  function automatic logic [DMEM_AW-1:0] ptr_step(input logic [DMEM_AW-1:0] p, input logic up);
    if (up) return (p == DMEM_AW'(DMEMSIZE-1)) ? '0 : p + DMEM_AW'(1);
    return (p == '0) ? DMEM_AW'(DMEMSIZE-1) : p - DMEM_AW'(1);
  endfunction
endpackage

// File: rtl/dmem_ctrl_if.sv
// Sample handshake, dmem command bus and tap stream of the delay-line sequencer.
// master = the sequencer itself, slave = source/dmem/MAC side.
interface dmem_ctrl_if #(parameter int TAPS = myfilter_pkg::DMEM_TAPS);
  import myfilter_pkg::*;
  localparam int IW = $clog2(TAPS+1);

  logic                clear_in;
  logic                sample_valid_in;
  logic                sample_ready_out;
  logic [DATABITS-1:0] sample_in;
  dmem_cmd_t           dmem_cmd_out;
  logic [DMEM_AW-1:0]  dmem_addr_out;
  logic [DATABITS-1:0] dmem_ext_out;
  logic [DATABITS-1:0] dmem_d_in;
  logic                tap_valid_out;
  logic [DATABITS-1:0] tap_data_out;
  logic [IW-1:0]       tap_idx_out;
  logic                tap_last_out;
  logic                busy_out;

  modport master (
    input  clear_in, sample_valid_in, sample_in, dmem_d_in,
    output sample_ready_out, dmem_cmd_out, dmem_addr_out, dmem_ext_out,
           tap_valid_out, tap_data_out, tap_idx_out, tap_last_out, busy_out
  );
  modport slave (
    output clear_in, sample_valid_in, sample_in, dmem_d_in,
    input  sample_ready_out, dmem_cmd_out, dmem_addr_out, dmem_ext_out,
           tap_valid_out, tap_data_out, tap_idx_out, tap_last_out, busy_out
  );
endinterface

// File: rtl/dmem_ctrl_sva.sv
// Protocol assertions for dmem_ctrl, bound into every instance.
module dmem_ctrl_sva import myfilter_pkg::*; #(
  parameter int TAPS = DMEM_TAPS
) (
  input logic                       clk,
  input logic                       rst_n,
  input dmem_ctrl_state_t           state,
  input dmem_cmd_t                  cmd,
  input logic                       tap_valid,
  input logic                       tap_last,
  input logic [$clog2(TAPS+1)-1:0]  tap_idx
);
  localparam int IW = $clog2(TAPS+1);

  if (TAPS < 1 || TAPS > DMEMSIZE) begin : g_taps_range
    $error("dmem_ctrl: TAPS must lie in 1..DMEMSIZE");
  end

  a_idle_nop: assert property (@(posedge clk) disable iff (!rst_n)
    state == ST_IDLE |-> cmd == DMEM_NOP);
  a_last_idx: assert property (@(posedge clk) disable iff (!rst_n)
    tap_valid |-> (tap_last == (tap_idx == IW'(TAPS-1))));
  a_last_vld: assert property (@(posedge clk) disable iff (!rst_n)
    tap_last |-> tap_valid);
  a_last_end: assert property (@(posedge clk) disable iff (!rst_n)
    tap_last |=> !tap_valid);
endmodule

bind dmem_ctrl dmem_ctrl_sva #(.TAPS(TAPS)) u_sva (
  .clk(clk), .rst_n(rst_n), .state(state), .cmd(req.cmd),
  .tap_valid(tap_vld), .tap_last(tap_last), .tap_idx(tap_idx)
);

// File: rtl/dmem_ptr_wrap.sv
// Modulo-DMEMSIZE up/down pointer; nxt exposes the value the pointer takes at
// the coming edge so callers can register it elsewhere in the same cycle.
module dmem_ptr_wrap import myfilter_pkg::*; (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [DMEM_AW-1:0] load_val,
  input  logic               inc,
  input  logic               dec,
  output logic [DMEM_AW-1:0] ptr,
  output logic [DMEM_AW-1:0] nxt
);
  always_comb begin
    nxt = ptr;
    if (load)     nxt = load_val;
    else if (inc) nxt = ptr_step(ptr, 1'b1);
    else if (dec) nxt = ptr_step(ptr, 1'b0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= '0;
    else        ptr <= nxt;
  end
endmodule

// File: rtl/dmem_ctrl.sv
// Delay-line sequencer: writes each accepted sample at the circular head, then
// bursts the newest TAPS words out of dmem, newest first, to the MAC.
module dmem_ctrl import myfilter_pkg::*; #(
  parameter int TAPS = DMEM_TAPS
) (
  input  logic       clk,
  input  logic       rst_n,
  dmem_ctrl_if.master bus
);
  localparam int CW = $clog2(DMEMSIZE+1);
  localparam int IW = $clog2(TAPS+1);
  localparam logic [CW-1:0] INIT_END = CW'(DMEMSIZE);
  localparam logic [CW-1:0] TAP_END  = CW'(TAPS-1);

  dmem_ctrl_state_t   state;
  logic [CW-1:0]      cnt;
  dmem_req_t          req;
  logic               tap_vld, tap_last;
  logic [IW-1:0]      tap_idx;
  logic [DMEM_AW-1:0] head, head_nxt, rp, rp_nxt;
  logic               rd_last;

  assign rd_last = (state == ST_READ) && (cnt == TAP_END);

  dmem_ptr_wrap u_head (
    .clk(clk), .rst_n(rst_n), .load(state == ST_INIT), .load_val('0),
    .inc(state == ST_DRAIN), .dec(1'b0), .ptr(head), .nxt(head_nxt)
  );

  dmem_ptr_wrap u_rp (
    .clk(clk), .rst_n(rst_n), .load(state == ST_WRITE), .load_val(head),
    .inc(1'b0), .dec(state == ST_READ), .ptr(rp), .nxt(rp_nxt)
  );

  // dmem request is registered: each edge sets up the command for the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      cnt      <= '0;
      req      <= '{DMEM_NOP, '0, '0};
      tap_vld  <= 1'b0;
      tap_idx  <= '0;
      tap_last <= 1'b0;
    end else begin
      req.cmd  <= DMEM_NOP;
      tap_vld  <= (state == ST_READ);
      tap_idx  <= (state == ST_READ) ? cnt[IW-1:0] : '0;
      tap_last <= rd_last;
      case (state)
        ST_INIT: begin
          if (cnt == INIT_END) state <= ST_IDLE;
          else begin
            req <= '{DMEM_WRITE, cnt[DMEM_AW-1:0], '0};
            cnt <= cnt + CW'(1);
          end
        end
        ST_IDLE: begin
          // Clear issues the first zeroing write itself so INIT stays DMEMSIZE cycles.
          if (bus.clear_in) begin
            state <= ST_INIT;
            req   <= '{DMEM_WRITE, '0, '0};
            cnt   <= CW'(1);
          end else if (bus.sample_valid_in) begin
            state <= ST_WRITE;
            req   <= '{DMEM_WRITE, head_nxt, bus.sample_in};
          end
        end
        ST_WRITE: begin
          state <= ST_READ;
          cnt   <= '0;
          req   <= '{DMEM_READ, rp_nxt, '0};
        end
        ST_READ: begin
          if (rd_last) state <= ST_DRAIN;
          else begin
            cnt      <= cnt + CW'(1);
            req.cmd  <= DMEM_READ;
            req.addr <= rp_nxt;
          end
        end
        ST_DRAIN: state <= ST_IDLE;
        default:  state <= ST_INIT;
      endcase
    end
  end

  assign bus.sample_ready_out = (state == ST_IDLE) && !bus.clear_in;
  assign bus.busy_out         = (state != ST_IDLE);
  assign bus.dmem_cmd_out     = req.cmd;
  assign bus.dmem_addr_out    = req.addr;
  assign bus.dmem_ext_out     = req.ext;
  assign bus.tap_valid_out    = tap_vld;
  assign bus.tap_data_out     = bus.dmem_d_in;
  assign bus.tap_idx_out      = tap_idx;
  assign bus.tap_last_out     = tap_last;
endmodule
